// File: rtl/reg_file_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : reg_file_ctrl_if
// Brief    : Host access bundle for reg_file_ctrl (strobes, address, data, status).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface reg_file_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          clr_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wdata_i;
    logic [DW-1:0] wmask_i;
    logic          wen_i;
    logic          ren_i;
    logic [DW-1:0] rdata_o;
    logic          rvalid_o;
    logic          busy_o;
    logic          err_o;

    modport master (
        output clr_i, addr_i, wdata_i, wmask_i, wen_i, ren_i,
        input  rdata_o, rvalid_o, busy_o, err_o
    );

    modport slave (
        input  clr_i, addr_i, wdata_i, wmask_i, wen_i, ren_i,
        output rdata_o, rvalid_o, busy_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : reg_file_ctrl
// Brief    : Register file with masked writes, background clear sweep and access-error flag.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module reg_file_ctrl #(
    parameter int            DW    = 8,
    parameter int            AW    = 8,
    parameter int            DEPTH = 256,
    parameter logic [DW-1:0] INIT  = '0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    reg_file_ctrl_if.slave   bus
);

    localparam int            c_cw        = $clog2(DEPTH) + 1;
    localparam int            c_iw        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   c_depth_ext = (AW+1)'(DEPTH);
    localparam logic [c_cw-1:0] c_last    = c_cw'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [c_cw-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;

    logic [DW-1:0]     mem_q [DEPTH];
    logic              mem_we;
    logic [c_iw-1:0]   mem_waddr;
    logic [DW-1:0]     mem_wdata;

    logic              w_in_range;
    logic              w_reject;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [c_iw-1:0]   w_idx;
    logic [DW-1:0]     w_rd_word;

    assign w_idx      = bus.addr_i[c_iw-1:0];
    assign w_rd_word  = mem_q[w_idx];
    assign w_in_range = ({1'b0, bus.addr_i} < c_depth_ext);
    // Any strobe is refused while sweeping, alongside a clear, or past the last entry.
    assign w_reject   = (bus.wen_i | bus.ren_i) &
                        ((state_q != S_READY) | bus.clr_i | ~w_in_range);
    assign w_wr_ok    = bus.wen_i & ~w_reject;
    assign w_rd_ok    = bus.ren_i & ~w_reject;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        rvalid_d  = bus.ren_i;
        err_d     = w_reject;
        mem_we    = 1'b0;
        mem_waddr = w_idx;
        mem_wdata = (w_rd_word & ~bus.wmask_i) | (bus.wdata_i & bus.wmask_i);

        // Read-first: the read port sees the word before this cycle's write lands.
        if (w_rd_ok) begin
            rdata_d = w_rd_word;
        end else if (bus.ren_i) begin
            rdata_d = '0;
        end

        if (bus.clr_i) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
        end else if (state_q == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q[c_iw-1:0];
            mem_wdata = INIT;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == c_last) begin
                state_d = S_READY;
            end
        end else if (w_wr_ok) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_CLEAR;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Storage has no reset; it is only ever initialised by the sweep.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.rdata_o  = rdata_q;
    assign bus.rvalid_o = rvalid_q;
    assign bus.err_o    = err_q;
    assign bus.busy_o   = (state_q == S_CLEAR);

endmodule
`default_nettype wire

// File: doc/reg_file_ctrl.md
# reg_file_ctrl

Parametrised register file with a synchronous read/write host port, bit-masked writes, a background clear sequencer and access-error reporting. It replaces the fixed 256×8 register file model in the peripheral benches and RTL. Configuration registers for blocks such as the UART live here and are accessed by the bus/host model. Unlike a plain memory, clearing is a visible multi-cycle operation (busy_o), and illegal accesses are flagged rather than silently dropped.

## Interface
- DW, 8: data width in bits (1..32).
- AW, 8: address width in bits.
- DEPTH, 256: number of implemented entries, 1..2**AW.
- INIT, 0: DW-bit value written to every entry by a clear sweep.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clr_i  in  1  soft-clear request; one-cycle pulse starts a clear sweep.
- addr_i  in  AW  entry address for read and write.
- wdata_i  in  DW  write data.
- wmask_i  in  DW  per-bit write enable; 1 = update bit.
- wen_i  in  1  write strobe.
- ren_i  in  1  read strobe.
- rdata_o  out  DW  read data, registered.
- rvalid_o  out  1  one-cycle pulse: rdata_o holds new read result.
- busy_o  out  1  clear sweep in progress; accesses are rejected.
- err_o  out  1  one-cycle pulse: previous-cycle access was rejected.

## Operation
- FSM has 2 states. CLEAR has busy_o=1; READY has busy_o=0.
- Sweep counter cnt is sized $clog2(DEPTH)+1.
- rst high: state=CLEAR, cnt=0, no memory write. rdata_o=0, rvalid_o=0, err_o=0, busy_o=1.
- CLEAR, rst low: each cycle writes mem[cnt]=INIT and increments cnt. Write at cnt==DEPTH-1 moves state to READY.
- clr_i in any state (rst low): next state=CLEAR with cnt=0. A clr_i during CLEAR restarts the sweep from 0.
- READY write (wen_i=1, addr_i<DEPTH): mem[addr] <= (mem[addr] & ~wmask_i) | (wdata_i & wmask_i).
- READY read (ren_i=1, addr_i<DEPTH): rdata_o <= mem[addr], rvalid_o=1 next cycle.
- A simultaneous wen_i and ren_i to the same address is read-first: rdata_o returns the pre-write contents.
- Rejection: access (wen_i|ren_i) while state=CLEAR, or in the same cycle as clr_i, or with addr_i>=DEPTH.
  - err_o=1 next cycle and memory is unchanged.
  - A rejected read also gives rdata_o=0 and rvalid_o=1 next cycle.
- rdata_o holds its last value when there is no read. rvalid_o and err_o are 0 except for their one-cycle pulses.
- Memory contents are undefined from power-up until the first sweep completes. Contents are not altered by rst except through the sweep.

## Timing
- Read latency is 1 cycle (strobe in cycle N, data and rvalid_o in N+1). Write takes effect at the edge of cycle N; a read in cycle N+1 sees it.
- Reads and writes are accepted back-to-back every cycle in READY; there is no handshake back-pressure. The host must sample busy_o before issuing.
- Sweep timing after rst falls or after clr_i:
  - busy_o stays 1 for exactly DEPTH cycles after the last rst-high cycle, or after the clr_i cycle.
  - busy_o is 0 in the cycle after mem[DEPTH-1] is written.
- err_o is asserted exactly 1 cycle after the offending strobe, with one pulse per offending cycle.
- rst asserted mid-sweep or mid-access: the next state is CLEAR with cnt=0. Pending rvalid_o and err_o are forced to 0.

## Test plan
- Reset release (DW=8, DEPTH=256, INIT=8'h00): count cycles until busy_o=0 -> exactly 256. rdata_o=0, rvalid_o=0 and err_o=0 throughout.
- Masked write: write 8'hFF mask 8'hFF to addr 8'h10, then 8'h00 mask 8'h0F. Read 8'h10 -> rdata_o=8'hF0 with rvalid_o one cycle after ren_i.
- Read-first collision: mem[8'h20]=8'h55, then the same cycle has wen_i 8'hAA (mask FF) and ren_i at 8'h20. Response: rdata_o=8'h55; the next read gives 8'hAA.
- Access during sweep: pulse clr_i, write 8'h77 to 8'h05 two cycles later. Response: err_o pulse, and after busy_o falls a read of 8'h05 gives INIT.
- Restart and rst mid-sweep:
  - clr_i again at sweep cycle 100: busy_o lasts 256 more cycles.
  - rst at sweep cycle 50: busy_o lasts 256 cycles after rst falls.
- Out-of-range (DEPTH=200): read 8'hC8 gives rdata_o=0, rvalid_o=1 and err_o=1. Write 8'hC8 gives err_o=1, and a read of 8'h00 is unchanged.
